// File: rtl/clint_trap_seq.sv
// clint_trap_seq: machine-mode trap entry (mepc, mstatus, mcause writes) and mret sequencing.
// Latency: uncontended trap request at cycle N -> int_assert_o at N+4; mret -> N+2.
// Backpressure: each CSR-write state holds while ex_csr_we_i=1; requests outside IDLE are ignored.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   ecall_i/ebreak_i/mret_i          one-cycle decoded requests from ID
//   timer_irq_i, global_int_en_i     level timer interrupt and mstatus.MIE
//   inst_addr_i                      PC of the instruction in ID (saved as mepc)
//   ex_csr_we_i                      EX stage is using the CSR write port this cycle
//   csr_mtvec_i/mepc_i/mstatus_i     live CSR values
//   clint_we_o/waddr_o/raddr_o/data_o  second CSR write port (12-bit address zero-extended)
//   hold_flag_o                      pipeline stall while a sequence is in flight
//   int_assert_o, int_addr_o         one-cycle redirect strobe and target
// Option: define CLINT_TIMER_INT_EN to sequence timer interrupts; otherwise timer_irq_i is ignored.
module clint_trap_seq #(
  parameter logic [63:0] TIMER_CAUSE = 64'h8000_0000_0000_0007
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        mret_i,
  input  logic        timer_irq_i,
  input  logic [63:0] inst_addr_i,
  input  logic        ex_csr_we_i,
  input  logic        global_int_en_i,
  input  logic [63:0] csr_mtvec_i,
  input  logic [63:0] csr_mepc_i,
  input  logic [63:0] csr_mstatus_i,
  output logic        clint_we_o,
  output logic [63:0] clint_waddr_o,
  output logic [63:0] clint_raddr_o,
  output logic [63:0] clint_data_o,
  output logic        hold_flag_o,
  output logic        int_assert_o,
  output logic [63:0] int_addr_o
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [63:0] CAUSE_ECALL  = 64'd11;
  localparam logic [63:0] CAUSE_EBREAK = 64'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_MEPC,
    S_W_MSTATUS,
    S_W_MCAUSE,
    S_R_MSTATUS,
    S_ASSERT
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] cause_q, cause_d;
  logic        mret_q, mret_d;

  logic        timer_req;
  logic        accept;
  logic        wr_state;
  logic [11:0] csr_addr;
  logic [63:0] wr_data;
  logic [63:0] mstatus_trap;
  logic [63:0] mstatus_mret;

`ifdef CLINT_TIMER_INT_EN
  assign timer_req = timer_irq_i & global_int_en_i;
`else
  // Timer inputs are deliberately unconnected in this build.
  logic unused_timer;
  assign unused_timer = timer_irq_i & global_int_en_i;
  assign timer_req    = 1'b0;
`endif

  // Only IDLE accepts work; reset blocks acceptance so nothing starts under reset.
  assign accept = ~rst & (state_q == S_IDLE) & (mret_i | ecall_i | ebreak_i | timer_req);

  // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- M. mret: MIE <- MPIE, MPIE <- 1.
  always_comb begin
    mstatus_trap        = csr_mstatus_i;
    mstatus_trap[7]     = csr_mstatus_i[3];
    mstatus_trap[3]     = 1'b0;
    mstatus_trap[12:11] = 2'b11;
    mstatus_mret        = csr_mstatus_i;
    mstatus_mret[3]     = csr_mstatus_i[7];
    mstatus_mret[7]     = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cause_d = cause_q;
    mret_d  = mret_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          pc_d   = inst_addr_i;
          mret_d = mret_i;
          if (mret_i) begin
            state_d = S_R_MSTATUS;
          end else begin
            state_d = S_W_MEPC;
            if (ecall_i)       cause_d = CAUSE_ECALL;
            else if (ebreak_i) cause_d = CAUSE_EBREAK;
            else               cause_d = TIMER_CAUSE;
          end
        end
      end
      // Write states advance only once EX releases the CSR write port.
      S_W_MEPC:    if (!ex_csr_we_i) state_d = S_W_MSTATUS;
      S_W_MSTATUS: if (!ex_csr_we_i) state_d = S_W_MCAUSE;
      S_W_MCAUSE:  if (!ex_csr_we_i) state_d = S_ASSERT;
      S_R_MSTATUS: if (!ex_csr_we_i) state_d = S_ASSERT;
      S_ASSERT:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      mret_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      mret_q  <= mret_d;
    end
  end

  // Write-port contents decode straight from the registered state.
  always_comb begin
    wr_state = 1'b0;
    csr_addr = '0;
    wr_data  = '0;
    case (state_q)
      S_W_MEPC:    begin wr_state = 1'b1; csr_addr = CSR_MEPC;    wr_data = pc_q;         end
      S_W_MSTATUS: begin wr_state = 1'b1; csr_addr = CSR_MSTATUS; wr_data = mstatus_trap; end
      S_W_MCAUSE:  begin wr_state = 1'b1; csr_addr = CSR_MCAUSE;  wr_data = cause_q;      end
      S_R_MSTATUS: begin wr_state = 1'b1; csr_addr = CSR_MSTATUS; wr_data = mstatus_mret; end
      default:     ;
    endcase
  end

  // Reset forces every output low, so an aborted sequence cannot emit a late write.
  assign clint_we_o    = ~rst & wr_state & ~ex_csr_we_i;
  assign clint_waddr_o = rst ? '0 : {52'd0, csr_addr};
  assign clint_raddr_o = rst ? '0 : {52'd0, csr_addr};
  assign clint_data_o  = rst ? '0 : wr_data;
  assign int_assert_o  = ~rst & (state_q == S_ASSERT);
  assign int_addr_o    = int_assert_o ? (mret_q ? csr_mepc_i : csr_mtvec_i) : '0;
  assign hold_flag_o   = ~rst & ((state_q != S_IDLE) | accept);

endmodule

// File: tb/tb_clint_trap_seq.sv
module tb_clint_trap_seq;

  localparam logic [63:0] TCAUSE = 64'h8000_0000_0000_0007;
  localparam logic [63:0] NONE   = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef CLINT_TIMER_INT_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  localparam int K_FIX     = 0;
  localparam int K_MS_TRAP = 1;
  localparam int K_MS_MRET = 2;
  localparam int K_A_TVEC  = 3;
  localparam int K_A_EPC   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ecall, ebreak, mret, timer, mie, ex_we;
  logic [63:0] inst_addr, mtvec, mepc, mstatus;
  logic        we_o, hold_o, as_o;
  logic [63:0] waddr_o, raddr_o, data_o, iaddr_o;

  always #5 clk = ~clk;

  clint_trap_seq #(.TIMER_CAUSE(TCAUSE)) dut (
    .clk(clk), .rst(rst),
    .ecall_i(ecall), .ebreak_i(ebreak), .mret_i(mret),
    .timer_irq_i(timer), .inst_addr_i(inst_addr),
    .ex_csr_we_i(ex_we), .global_int_en_i(mie),
    .csr_mtvec_i(mtvec), .csr_mepc_i(mepc), .csr_mstatus_i(mstatus),
    .clint_we_o(we_o), .clint_waddr_o(waddr_o), .clint_raddr_o(raddr_o),
    .clint_data_o(data_o), .hold_flag_o(hold_o),
    .int_assert_o(as_o), .int_addr_o(iaddr_o)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: a queue of pending port actions that the sequencer owes.
  typedef struct {
    int          kind;
    logic [11:0] addr;
    logic [63:0] val;
  } step_t;
  step_t plan[$];

  // Observation log of what the DUT actually did.
  logic [63:0] obs_mepc, obs_ms, obs_mcause, obs_as_addr;
  int          obs_ms_cyc, obs_as_cyc, n_writes, n_asserts;

  task automatic clear_obs();
    obs_mepc = NONE; obs_ms = NONE; obs_mcause = NONE; obs_as_addr = NONE;
    obs_ms_cyc = -1; obs_as_cyc = -1; n_writes = 0; n_asserts = 0;
  endtask

  function automatic logic [63:0] ms_trap(input logic [63:0] m);
    return (m & ~64'h88) | (m[3] ? 64'h80 : 64'h0) | 64'h1800;
  endfunction

  function automatic logic [63:0] ms_mret(input logic [63:0] m);
    return (m & ~64'h8) | (m[7] ? 64'h8 : 64'h0) | 64'h80;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic tick();
    logic        e_we, e_as, e_hold;
    logic [63:0] e_wa, e_wd, e_ia, cause;
    bit          acc, pop;
    #1;
    e_we = 0; e_as = 0; e_wa = 0; e_wd = 0; e_ia = 0; acc = 0; pop = 0;
    if (rst) begin
      plan.delete();
    end else if (plan.size() > 0) begin
      case (plan[0].kind)
        K_A_TVEC: begin e_as = 1; e_ia = mtvec; pop = 1; end
        K_A_EPC:  begin e_as = 1; e_ia = mepc;  pop = 1; end
        default: begin
          e_wa = {52'd0, plan[0].addr};
          e_wd = (plan[0].kind == K_FIX)     ? plan[0].val :
                 (plan[0].kind == K_MS_TRAP) ? ms_trap(mstatus) : ms_mret(mstatus);
          e_we = !ex_we;
          pop  = !ex_we;
        end
      endcase
    end else begin
      acc = mret | ecall | ebreak | (TIMER_EN & timer & mie);
    end
    e_hold = !rst && (plan.size() > 0 || acc);

    check("we", 64'(we_o), 64'(e_we));
    check("waddr", waddr_o, e_wa);
    check("raddr", raddr_o, e_wa);
    check("wdata", data_o, e_wd);
    check("assert", 64'(as_o), 64'(e_as));
    check("int_addr", iaddr_o, e_ia);
    check("hold", 64'(hold_o), 64'(e_hold));

    if (we_o) begin
      n_writes++;
      if (waddr_o == 64'h341) obs_mepc = data_o;
      if (waddr_o == 64'h342) obs_mcause = data_o;
      if (waddr_o == 64'h300) begin obs_ms = data_o; obs_ms_cyc = cyc; end
    end
    if (as_o) begin
      n_asserts++;
      obs_as_cyc  = cyc;
      obs_as_addr = iaddr_o;
    end

    if (pop) void'(plan.pop_front());
    if (acc) begin
      if (mret) begin
        plan.push_back('{K_MS_MRET, 12'h300, 64'd0});
        plan.push_back('{K_A_EPC, 12'h000, 64'd0});
      end else begin
        cause = ecall ? 64'd11 : (ebreak ? 64'd3 : TCAUSE);
        plan.push_back('{K_FIX, 12'h341, inst_addr});
        plan.push_back('{K_MS_TRAP, 12'h300, 64'd0});
        plan.push_back('{K_FIX, 12'h342, cause});
        plan.push_back('{K_A_TVEC, 12'h000, 64'd0});
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic quiet();
    ecall = 0; ebreak = 0; mret = 0; timer = 0; ex_we = 0;
  endtask

  task automatic drain();
    quiet();
    for (int i = 0; i < 20 && plan.size() > 0; i++) tick();
    check("drain_idle", 64'(hold_o), 64'd0);
  endtask

  int req;

  initial begin
    quiet();
    rst = 1; mie = 0;
    inst_addr = 0; mtvec = 0; mepc = 0; mstatus = 0;
    clear_obs();
    @(negedge clk);
    ecall = 1;              // request under reset must be ignored
    tick();
    ecall = 0;
    tick();
    check("reset_hold", 64'(hold_o), 64'd0);
    rst = 0;
    tick();

    // ecall trap entry
    clear_obs();
    mstatus = 64'h8; mtvec = 64'h8000_1000; inst_addr = 64'h8000_0010;
    ecall = 1; req = cyc; tick(); ecall = 0;
    repeat (6) tick();
    check("ecall_mepc", obs_mepc, 64'h8000_0010);
    check("ecall_mstatus", obs_ms, 64'h1880);
    check("ecall_mcause", obs_mcause, 64'd11);
    check("ecall_latency", 64'(obs_as_cyc - req), 64'd4);
    check("ecall_target", obs_as_addr, 64'h8000_1000);

    // mret
    clear_obs();
    mstatus = 64'h1880; mepc = 64'h8000_0014;
    mret = 1; req = cyc; tick(); mret = 0;
    repeat (4) tick();
    check("mret_mstatus", obs_ms, 64'h1888);
    check("mret_latency", 64'(obs_as_cyc - req), 64'd2);
    check("mret_target", obs_as_addr, 64'h8000_0014);
    check("mret_writes", 64'(n_writes), 64'd1);

    // ecall wins over a simultaneous timer; timer follows if still pending
    clear_obs();
    mstatus = 64'h8; mie = 1; timer = 1; ecall = 1; inst_addr = 64'h8000_0020;
    tick(); ecall = 0;
    repeat (4) tick();
    check("prio_mcause", obs_mcause, 64'd11);
    clear_obs();
    repeat (8) tick();
    check("timer_follow_mcause", obs_mcause, TIMER_EN ? TCAUSE : NONE);
    drain();

    // EX holds the CSR port for two cycles during the mstatus write
    clear_obs();
    mstatus = 64'h8; mtvec = 64'h8000_2000; inst_addr = 64'h8000_0030;
    ecall = 1; req = cyc; tick(); ecall = 0;
    tick();
    ex_we = 1; tick(); tick(); ex_we = 0;
    repeat (5) tick();
    check("stall_ms_cycle", 64'(obs_ms_cyc - req), 64'd4);
    check("stall_latency", 64'(obs_as_cyc - req), 64'd6);
    check("stall_mstatus", obs_ms, 64'h1880);

    // reset in the middle of a trap sequence
    clear_obs();
    ecall = 1; tick(); ecall = 0;
    tick();
    rst = 1; tick(); rst = 0;
    repeat (6) tick();
    check("abort_mcause", obs_mcause, NONE);
    check("abort_asserts", 64'(n_asserts), 64'd0);
    check("abort_writes", 64'(n_writes), 64'd1);

    // timer with MIE=0, then MIE=1
    clear_obs();
    mie = 0; timer = 1;
    repeat (6) tick();
    check("timer_mie0_writes", 64'(n_writes), 64'd0);
    check("timer_mie0_hold", 64'(hold_o), 64'd0);
    clear_obs();
    mie = 1;
    repeat (6) tick();
    check("timer_mie1_writes", 64'(n_writes), TIMER_EN ? 64'd3 : 64'd0);
    drain();

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      ecall     = ($urandom_range(0, 7) == 0);
      ebreak    = ($urandom_range(0, 7) == 0);
      mret      = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) timer = ~timer;
      mie       = $urandom_range(0, 1) != 0;
      ex_we     = ($urandom_range(0, 3) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      inst_addr = rnd64();
      mtvec     = rnd64();
      mepc      = rnd64();
      mstatus   = rnd64();
      tick();
    end
    rst = 0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clint_trap_seq.md
CLINT_TRAP_SEQ -- requirements
Module: clint_trap_seq

Interface
REQ-001 Parameter: TIMER_CAUSE, 64'h8000_0000_0000_0007, mcause value written for a timer interrupt.
REQ-002 Port: clk  in  1  single clock; all logic on posedge clk.
REQ-003 Port: rst  in  1  reset, synchronous and active-high.
REQ-004 Ports: ecall_i, ebreak_i, mret_i  in  1 each  decoded trap/return requests from ID, one-cycle pulses.
REQ-005 Ports: timer_irq_i  in  1  level timer interrupt; inst_addr_i  in  64  PC of the instruction in ID.
REQ-006 Ports: ex_csr_we_i  in  1  EX-stage CSR write active; global_int_en_i  in  1  mstatus.MIE.
REQ-007 Ports: csr_mtvec_i, csr_mepc_i, csr_mstatus_i  in  64 each  live CSR values.
REQ-008 Ports: clint_we_o  out  1, clint_waddr_o  out  64, clint_raddr_o  out  64, clint_data_o  out  64  CSR second write/read port.
REQ-009 Ports: hold_flag_o  out  1  pipeline stall; int_assert_o  out  1  redirect strobe; int_addr_o  out  64  redirect target.

Function
REQ-010 States: IDLE, W_MEPC, W_MSTATUS, W_MCAUSE, R_MSTATUS (mret), ASSERT.
REQ-011 In IDLE, accept one request per cycle; priority: mret > ecall > ebreak > timer.
REQ-012 Timer accepted only when TIMER_CAUSE path enabled (REQ-025), timer_irq_i=1 and global_int_en_i=1.
REQ-013 On acceptance, latch inst_addr_i as saved PC and cause (ecall 64'd11, ebreak 64'd3, timer TIMER_CAUSE).
REQ-014 Trap path: IDLE -> W_MEPC -> W_MSTATUS -> W_MCAUSE -> ASSERT -> IDLE; one CSR write per write state.
REQ-015 mret path: IDLE -> R_MSTATUS -> ASSERT -> IDLE.
REQ-016 W_MEPC writes addr 12'h341 with saved PC; W_MCAUSE writes 12'h342 with latched cause.
REQ-017 W_MSTATUS writes 12'h300: csr_mstatus_i with bit7 (MPIE) := bit3, bit3 := 0, bits[12:11] := 2'b11.
REQ-018 R_MSTATUS writes 12'h300: csr_mstatus_i with bit3 := bit7, bit7 := 1.
REQ-019 clint_waddr_o/clint_raddr_o zero-extended 12-bit CSR address; clint_raddr_o equals clint_waddr_o in write states, 0 otherwise.
REQ-020 Any write state with ex_csr_we_i=1: clint_we_o=0, state and data unchanged; write issued first cycle ex_csr_we_i=0.
REQ-021 ASSERT: int_assert_o=1 for exactly one cycle; int_addr_o = csr_mtvec_i (trap) or csr_mepc_i (mret); 0 otherwise.
REQ-022 hold_flag_o = 1 when state != IDLE or a request is accepted this cycle (combinational); requests arriving while not IDLE are ignored.
REQ-023 Uncontended latency: request at cycle N -> int_assert_o at N+4 (trap), N+2 (mret).

Reset
REQ-024 rst=1: state IDLE, latched PC/cause 0, all outputs 0; reset mid-sequence aborts with no further CSR writes.

Configuration
REQ-025 Macro CLINT_TIMER_INT_EN: defined -> timer interrupts sequenced per REQ-012; undefined -> timer_irq_i ignored, only ecall/ebreak/mret handled.

Verification
REQ-026 ecall at PC 0x8000_0010, mstatus 0x8, mtvec 0x8000_1000 -> writes mepc=0x8000_0010, mstatus=0x1880, mcause=11; int_assert_o at N+4, int_addr_o=0x8000_1000.
REQ-027 mret with mstatus 0x1880, mepc 0x8000_0014 -> mstatus write 0x1888; int_assert_o at N+2, int_addr_o=0x8000_0014.
REQ-028 ecall and timer_irq_i same cycle, MIE=1 -> mcause=11; timer taken on next IDLE if still asserted.
REQ-029 ex_csr_we_i high 2 cycles during W_MSTATUS -> no clint write those cycles, mstatus written third cycle, assert delayed 2 cycles.
REQ-030 rst asserted in W_MSTATUS -> no mcause write, no int_assert_o; timer with MIE=0 or macro undefined -> no sequence, hold_flag_o=0.
